ethansam9_counter: RTL and testbench
====================================

// Module: ethansam9_counter
// PURPOSE
//   Tiny Tapeout user tile: 8-bit programmable up/down counter driven onto uo_out.
//   Controls on ui_in: hold, direction, synchronous load, clear and a 4-bit prescaler.
//   Sits directly under the TT harness; all I/O follows the standard tt_um pinout.
// PARAMETERS
//   WIDTH     8   counter width; fixed by the uo_out width, not to be overridden
//   PRE_BITS  4   prescaler select width (ui_in[7:4])
// PORTS
//   clk      in   1  single clock; all state on rising edge
//   rst_n    in   1  asynchronous active-low reset
//   ena      in   1  tile enable; low freezes all state
//   ui_in    in   8  [0] hold, [1] dir (0 up, 1 down), [2] load, [3] clear, [7:4] prescale select
//   uo_out   out  8  current count value (registered)
//   uio_in   in   8  load data
//   uio_out  out  8  0x00 (see CONFIGURATION)
//   uio_oe   out  8  0x00, all bidirs are inputs (see CONFIGURATION)
// BEHAVIOUR
//   Reset (rst_n=0, async): count=0, prescaler=0, uo_out=0x00, wrap flag=0.
//   Per rising edge with ena=1, priority high->low:
//     clear=1 -> count<=0, prescaler<=0
//     load=1  -> count<=uio_in, prescaler<=0
//     hold=1  -> count and prescaler unchanged
//     else tick when prescaler >= ui_in[7:4]: prescaler<=0, count<=count+1 (dir=0) or -1 (dir=1);
//          otherwise prescaler<=prescaler+1, count unchanged
//   ena=0: everything holds, including the prescaler; clear/load are ignored.
//   Prescale: select N gives one step every N+1 clocks; N=0 steps every clock.
//   Lowering N below the current prescaler value ticks on the next edge (>= compare).
//   Wrap-around modulo 256: 0xFF+1 -> 0x00, 0x00-1 -> 0xFF; no saturation.
//   Direction change takes effect on the next tick; no lost or double steps.
//   Latency: a control change on ui_in is sampled at the next edge; uo_out updates the same edge.
//   Reset mid-count clears immediately, without waiting for a clock edge.
// CONFIGURATION
//   COUNTER_WRAP_FLAG_EN undefined: uio_oe=0x00, uio_out=0x00, load data = uio_in[7:0].
//   COUNTER_WRAP_FLAG_EN defined: uio_oe=0x80; uio_out[7] = registered 1-cycle pulse
//     asserted on the edge following a tick that wraps (0xFF->0x00 up or 0x00->0xFF down);
//     uio_out[6:0]=0; load data = {1'b0, uio_in[6:0]}. Clear and load never raise the flag.
// STRUCTURE
//   Package ethansam9_counter_pkg: WIDTH, PRE_BITS, ui_in bit-index constants
//     (HOLD_BIT=0, DIR_BIT=1, LOAD_BIT=2, CLR_BIT=3, PRE_LSB=4).
//   Sub-module ethansam9_prescaler: 4-bit divider with clear/hold inputs and a tick output.
//   Top: control priority logic, count register, optional wrap flag, tie-offs.
// TESTING
//   ui_in=0, ena=1, reset released at 12 ns, clk 10 ns -> uo_out increments each edge, 20 after 20 edges.
//   Count to 0xFF, then one more edge -> uo_out=0x00; with dir=1 from 0x00 -> 0xFF.
//   uio_in=0xA5, pulse load -> uo_out=0xA5 next edge; load+clear together -> uo_out=0x00.
//   ui_in[7:4]=3 -> uo_out steps once per 4 clocks; hold=1 freezes the count; ena=0 freezes it too.
//   rst_n asserted mid-count between edges -> uo_out=0x00 immediately; resumes from 0 after release.
//   With COUNTER_WRAP_FLAG_EN: uio_oe=0x80, uio_out[7] pulses exactly one cycle at 0xFF->0x00.

Source files
------------

// File: rtl/ethansam9_counter_pkg.sv
// Shared constants, the control-priority enum and the wrap-detect helper for ethansam9_counter.
package ethansam9_counter_pkg;

  localparam int WIDTH    = 8;
  localparam int PRE_BITS = 4;

  localparam int HOLD_BIT = 0;
  localparam int DIR_BIT  = 1;
  localparam int LOAD_BIT = 2;
  localparam int CLR_BIT  = 3;
  localparam int PRE_LSB  = 4;

  // Resolved control action for one edge, highest priority first.
  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_LOAD  = 2'd1,
    OP_HOLD  = 2'd2,
    OP_RUN   = 2'd3
  } ctrlOp_e;

  function automatic logic wrapsOnStep(input logic [WIDTH-1:0] value, input logic down);
    return down ? (value == '0) : (value == '1);
  endfunction

endpackage

// File: rtl/ethansam9_prescaler.sv
// Prescale divider: emits a one-clock tick every sel_i+1 enabled, un-held clocks.
module ethansam9_prescaler
  import ethansam9_counter_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                hold_i,
  input  logic [PRE_BITS-1:0] sel_i,
  output logic                tick_o
);

  logic [PRE_BITS-1:0] pre_q;
  logic [PRE_BITS-1:0] pre_d;
  logic                reached;

  // A >= compare lets a lowered select fire on the very next edge.
  assign reached = (pre_q >= sel_i);
  assign tick_o  = reached & ~clr_i & ~hold_i;

  always_comb begin
    pre_d = pre_q;
    if (clr_i) begin
      pre_d = '0;
    end else if (!hold_i) begin
      pre_d = reached ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/ethansam9_counter.sv
// Tiny Tapeout 8-bit programmable up/down counter with prescaler, load, clear and hold.
// Define COUNTER_WRAP_FLAG_EN to drive a one-cycle wrap pulse on uio_out[7].
module ethansam9_counter
  import ethansam9_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  ctrlOp_e             op;
  logic                dirDown;
  logic [PRE_BITS-1:0] preSel;
  logic [WIDTH-1:0]    loadData;
  logic                tick;
  logic [WIDTH-1:0]    count_q;
  logic [WIDTH-1:0]    count_d;

  assign dirDown = ui_in[DIR_BIT];
  assign preSel  = ui_in[PRE_LSB +: PRE_BITS];

  always_comb begin
    op = OP_RUN;
    if (ui_in[CLR_BIT]) begin
      op = OP_CLEAR;
    end else if (ui_in[LOAD_BIT]) begin
      op = OP_LOAD;
    end else if (ui_in[HOLD_BIT]) begin
      op = OP_HOLD;
    end
  end

  // ena low must freeze the prescaler too, so it is folded into the hold input.
  ethansam9_prescaler uPrescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (ena & ((op == OP_CLEAR) | (op == OP_LOAD))),
    .hold_i (~ena | (op == OP_HOLD)),
    .sel_i  (preSel),
    .tick_o (tick)
  );

  always_comb begin
    count_d = count_q;
    case (op)
      OP_CLEAR: count_d = '0;
      OP_LOAD:  count_d = loadData;
      OP_HOLD:  count_d = count_q;
      default: begin
        if (tick) begin
          count_d = dirDown ? count_q - 1'b1 : count_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (ena) begin
      count_q <= count_d;
    end
  end

  assign uo_out = count_q;

`ifdef COUNTER_WRAP_FLAG_EN
  logic wrapFlag_q;
  logic wrapFlag_d;
  logic unusedBits;

  // Bit 7 of the bidir bus is an output here, so load data is only 7 bits wide.
  assign loadData   = {1'b0, uio_in[6:0]};
  assign unusedBits = uio_in[7];
  assign wrapFlag_d = (op == OP_RUN) & tick & wrapsOnStep(count_q, dirDown);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrapFlag_q <= 1'b0;
    end else if (ena) begin
      wrapFlag_q <= wrapFlag_d;
    end
  end

  assign uio_out = {wrapFlag_q, 7'b0};
  assign uio_oe  = 8'h80;
`else
  assign loadData = uio_in;
  assign uio_out  = 8'h00;
  assign uio_oe   = 8'h00;
`endif

endmodule

// File: tb/tb_ethansam9_counter.sv
// Bench for ethansam9_counter: directed literal checks plus randomized traffic against a model.
// Compile with +define+COUNTER_WRAP_FLAG_EN to also check the wrap pulse.
module tb_ethansam9_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int  vectors = 0;
  int  miscompares = 0;
  bit  checkOn = 1'b0;

  int  mCount = 0;
  int  mTicksSince = 0;
  bit  mFlag = 1'b0;

  ethansam9_counter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  function automatic int loadValue(input logic [7:0] data);
`ifdef COUNTER_WRAP_FLAG_EN
    return int'(data) % 128;
`else
    return int'(data);
`endif
  endfunction

  // Reference model: a step happens once select+1 enabled run-cycles have elapsed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mCount = 0;
      mTicksSince = 0;
      mFlag = 1'b0;
    end else if (ena) begin
      mFlag = 1'b0;
      if (ui_in[3]) begin
        mCount = 0;
        mTicksSince = 0;
      end else if (ui_in[2]) begin
        mCount = loadValue(uio_in);
        mTicksSince = 0;
      end else if (!ui_in[0]) begin
        if (mTicksSince >= int'(ui_in[7:4])) begin
          mTicksSince = 0;
          if (ui_in[1]) begin
            mFlag = (mCount == 0);
            mCount = (mCount + 255) % 256;
          end else begin
            mFlag = (mCount == 255);
            mCount = (mCount + 1) % 256;
          end
        end else begin
          mTicksSince = mTicksSince + 1;
        end
      end
    end
  end

  task automatic checkValue(input string name, input logic [7:0] actual, input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    checkValue("model_uo_out", uo_out, 8'(mCount));
`ifdef COUNTER_WRAP_FLAG_EN
    checkValue("model_uio_out", uio_out, {mFlag, 7'b0});
    checkValue("uio_oe", uio_oe, 8'h80);
`else
    checkValue("model_uio_out", uio_out, 8'h00);
    checkValue("uio_oe", uio_oe, 8'h00);
`endif
  endtask

  always @(negedge clk) begin
    if (checkOn) checkOutput();
  end

  task automatic applyStimulus(input logic [7:0] ui, input logic [7:0] uio, input logic en);
    @(negedge clk);
    ui_in = ui;
    uio_in = uio;
    ena = en;
  endtask

  task automatic stepAndExpect(input int edges, input string name, input logic [7:0] expected);
    repeat (edges) @(posedge clk);
    #1;
    checkValue(name, uo_out, expected);
  endtask

  initial begin
    #2;
    checkValue("reset_uo_out", uo_out, 8'h00);
    #10;
    rst_n = 1'b1;
    checkOn = 1'b1;
    stepAndExpect(20, "count20", 8'd20);

    // Wrap down from 0 then back up across the boundary.
    applyStimulus(8'h08, 8'h00, 1'b1);
    stepAndExpect(1, "clear", 8'h00);
    applyStimulus(8'h02, 8'h00, 1'b1);
    stepAndExpect(1, "wrapDown", 8'hFF);
`ifdef COUNTER_WRAP_FLAG_EN
    checkValue("wrapDownFlag", uio_out, 8'h80);
`endif
    applyStimulus(8'h00, 8'h00, 1'b1);
    stepAndExpect(1, "wrapUp", 8'h00);
`ifdef COUNTER_WRAP_FLAG_EN
    checkValue("wrapUpFlag", uio_out, 8'h80);
`endif
    stepAndExpect(1, "afterWrap", 8'h01);
`ifdef COUNTER_WRAP_FLAG_EN
    checkValue("flagOneCycle", uio_out, 8'h00);
`endif

    applyStimulus(8'h04, 8'hA5, 1'b1);
    stepAndExpect(1, "loadA5", 8'(loadValue(8'hA5)));
    applyStimulus(8'h0C, 8'h33, 1'b1);
    stepAndExpect(1, "loadClear", 8'h00);

    applyStimulus(8'h30, 8'h00, 1'b1);
    stepAndExpect(3, "pre3_3edges", 8'h00);
    stepAndExpect(1, "pre3_4edges", 8'h01);
    stepAndExpect(4, "pre3_8edges", 8'h02);

    applyStimulus(8'h01, 8'h00, 1'b1);
    stepAndExpect(5, "hold", 8'h02);
    applyStimulus(8'h08, 8'h00, 1'b0);
    stepAndExpect(5, "enaLow", 8'h02);

    applyStimulus(8'h00, 8'h00, 1'b1);
    stepAndExpect(3, "resumeRun", 8'h05);
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("resetMid", uo_out, 8'h00);
    #3;
    rst_n = 1'b1;
    stepAndExpect(3, "resumeAfterReset", 8'h03);

    for (int i = 0; i < 600; i++) begin
      logic [7:0] ui;
      ui[0] = ($urandom_range(0, 3) == 0);
      ui[1] = 1'($urandom);
      ui[2] = ($urandom_range(0, 11) == 0);
      ui[3] = ($urandom_range(0, 23) == 0);
      ui[7:4] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      applyStimulus(ui, 8'($urandom), ($urandom_range(0, 9) != 0));
    end
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
